// File: rtl/cpu_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one memory read per fetch request
// and hands the returned word to the instruction register, with misalignment and timeout faults.
module cpu_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch,
  input  logic        pc_wr,
  input  logic [31:0] pc_in,
  input  logic        fault_clr,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] ir_data,
  output logic        ir_wr,
  output logic [31:0] pc,
  output logic [31:0] inst_pc,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  typedef enum logic [1:0] {StIdle, StWait, StError} state_e;

  localparam logic [7:0] TimerMax = 8'(TIMEOUT - 1);

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_inst_pc, w_inst_pc_d;
  logic [7:0]  r_timer, w_timer_d;
  logic        r_done, w_done_d;
  logic [1:0]  r_cause, w_cause_d;
  logic [31:0] w_eff_addr;

  // A PC write in the same cycle as a fetch redirects that fetch.
  assign w_eff_addr = pc_wr ? pc_in : r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_pc      <= RESET_PC;
      r_inst_pc <= RESET_PC;
      r_timer   <= 8'd0;
      r_done    <= 1'b0;
      r_cause   <= 2'b00;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_inst_pc <= w_inst_pc_d;
      r_timer   <= w_timer_d;
      r_done    <= w_done_d;
      r_cause   <= w_cause_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_pc_d      = r_pc;
    w_inst_pc_d = r_inst_pc;
    w_timer_d   = r_timer;
    w_done_d    = 1'b0;
    w_cause_d   = r_cause;
    unique case (r_state)
      StIdle: begin
        if (fetch) begin
          w_pc_d = w_eff_addr;
          if (w_eff_addr[1:0] != 2'b00) begin
            w_state_d = StError;
            w_cause_d = 2'b01;
          end else begin
            w_inst_pc_d = w_eff_addr;
            w_timer_d   = 8'd0;
            w_state_d   = StWait;
          end
        end else if (pc_wr) begin
          w_pc_d = pc_in;
        end
      end
      StWait: begin
        // Acknowledge beats timeout when both land in the same cycle.
        if (mem_ack) begin
          w_pc_d    = r_inst_pc + 32'd4;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end else if (r_timer == TimerMax) begin
          w_state_d = StError;
          w_cause_d = 2'b10;
        end else begin
          w_timer_d = r_timer + 8'd1;
        end
      end
      StError: begin
        if (pc_wr) begin
          w_pc_d = pc_in;
        end
        if (fault_clr) begin
          w_cause_d = 2'b00;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign mem_rd      = (r_state == StWait);
  assign mem_addr    = r_inst_pc;
  assign ir_wr       = (r_state == StWait) && mem_ack;
  assign ir_data     = mem_data;
  assign pc          = r_pc;
  assign inst_pc     = r_inst_pc;
  assign busy        = (r_state == StWait);
  assign done        = r_done;
  assign fault       = (r_state == StError);
  assign fault_cause = r_cause;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: instruction words are queued when acks are driven
// and checked against ir_data when ir_wr is seen.
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch, pc_wr, fault_clr, mem_ack;
  logic [31:0] pc_in, mem_data;
  logic [31:0] mem_addr, ir_data, pc, inst_pc;
  logic        mem_rd, ir_wr, busy, done, fault;
  logic [1:0]  fault_cause;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];

  cpu_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch      (fetch),
    .pc_wr      (pc_wr),
    .pc_in      (pc_in),
    .fault_clr  (fault_clr),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .ir_data    (ir_data),
    .ir_wr      (ir_wr),
    .pc         (pc),
    .inst_pc    (inst_pc),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_cause(fault_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop: the DUT must be strobing ir_wr with the oldest queued word.
  task automatic expect_ir(input string tag);
    check({tag, "_ir_wr"}, 32'(ir_wr), 32'd1);
    total++;
    assert (exp_q.size() != 0)
    else begin
      bad++;
      $error("FAIL %s_queue observed=empty expected=word", tag);
    end
    if (exp_q.size() != 0) check({tag, "_ir_data"}, ir_data, exp_q.pop_front());
  endtask

  task automatic drive_ack(input logic [31:0] word);
    mem_ack  = 1'b1;
    mem_data = word;
    exp_q.push_back(word);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch = 1'b0; pc_wr = 1'b0; fault_clr = 1'b0; mem_ack = 1'b0;
    pc_in = 32'h0; mem_data = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    // Reset state, before any clock edge.
    check("rst_pc", pc, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Basic fetch at the reset PC.
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check("basic_mem_rd", 32'(mem_rd), 32'd1);
    check("basic_addr", mem_addr, 32'h0);
    drive_ack(32'h0000_0513);
    expect_ir("basic");
    check("basic_done_early", 32'(done), 32'd0);
    tick();
    mem_ack = 1'b0; #1;
    check("basic_done", 32'(done), 32'd1);
    check("basic_pc", pc, 32'h4);
    check("basic_inst_pc", inst_pc, 32'h0);
    check("basic_mem_rd_off", 32'(mem_rd), 32'd0);
    tick();
    check("basic_done_pulse", 32'(done), 32'd0);

    // Jump forwarded into fetch; fetch/pc_wr during WAIT must be ignored.
    pc_wr = 1'b1; pc_in = 32'h0000_0100; fetch = 1'b1;
    tick();
    pc_in = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      check("jump_addr_hold", mem_addr, 32'h100);
      check("jump_busy", 32'(busy), 32'd1);
      check("jump_ir_wr_idle", 32'(ir_wr), 32'd0);
      tick();
    end
    pc_wr = 1'b0; fetch = 1'b0;
    check("jump_addr_last", mem_addr, 32'h100);
    check("jump_pc_held", pc, 32'h100);
    drive_ack(32'h0010_0093);
    expect_ir("jump");
    tick();
    mem_ack = 1'b0;
    check("jump_pc", pc, 32'h104);
    check("jump_done", 32'(done), 32'd1);
    check("jump_fault", 32'(fault), 32'd0);

    // Misaligned forwarded target.
    pc_wr = 1'b1; pc_in = 32'h0000_0102; fetch = 1'b1; #1;
    check("mis_mem_rd_idle", 32'(mem_rd), 32'd0);
    tick();
    pc_wr = 1'b0;
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_cause", 32'(fault_cause), 32'd1);
    check("mis_pc", pc, 32'h102);
    check("mis_mem_rd", 32'(mem_rd), 32'd0);
    mem_ack = 1'b1; #1;
    check("err_ack_ignored", 32'(ir_wr), 32'd0);
    tick();
    mem_ack = 1'b0;
    check("mis_still_fault", 32'(fault), 32'd1);
    check("mis_mem_rd2", 32'(mem_rd), 32'd0);
    fault_clr = 1'b1; pc_wr = 1'b1; pc_in = 32'h0000_0200;
    tick();
    idle_inputs();
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_cause", 32'(fault_cause), 32'd0);
    check("clr_pc", pc, 32'h200);
    check("clr_mem_rd", 32'(mem_rd), 32'd0);

    // Timeout with no ack.
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_busy", 32'(busy), 32'd1);
      tick();
    end
    check("to_fault", 32'(fault), 32'd1);
    check("to_cause", 32'(fault_cause), 32'd2);
    check("to_pc", pc, 32'h200);
    check("to_mem_rd", 32'(mem_rd), 32'd0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("to_clr_cause", 32'(fault_cause), 32'd0);

    // Ack on the final WAIT cycle completes normally.
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    drive_ack(32'hDEAD_BEEF);
    expect_ir("to_ack");
    tick();
    mem_ack = 1'b0;
    check("to_ack_fault", 32'(fault), 32'd0);
    check("to_ack_done", 32'(done), 32'd1);
    check("to_ack_pc", pc, 32'h204);

    // Wrap at top of address space.
    pc_wr = 1'b1; pc_in = 32'hFFFF_FFFC; fetch = 1'b1;
    tick();
    pc_wr = 1'b0; fetch = 1'b0;
    check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    drive_ack(32'h0000_0073);
    expect_ir("wrap");
    tick();
    mem_ack = 1'b0;
    check("wrap_pc", pc, 32'h0);
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);

    // Reset mid-WAIT aborts the fetch; a late ack is ignored.
    pc_wr = 1'b1; pc_in = 32'h0000_0040; fetch = 1'b1;
    tick();
    idle_inputs();
    check("abort_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_rd", 32'(mem_rd), 32'd0);
    check("abort_pc", pc, 32'h0);
    check("abort_inst_pc", inst_pc, 32'h0);
    mem_ack = 1'b1; mem_data = 32'h1234_5678; #1;
    check("abort_ir_wr", 32'(ir_wr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_late_ir_wr", 32'(ir_wr), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pc_after", pc, 32'h0);
    mem_ack = 1'b0;

    // First fetch after reset reads RESET_PC.
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check("post_rst_addr", mem_addr, 32'h0);
    drive_ack(32'h0000_0297);
    expect_ir("post_rst");
    tick();
    mem_ack = 1'b0;
    check("post_rst_pc", pc, 32'h4);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
